// File: rtl/sound_pkg.sv
// Shared sound-subsystem constants: sample/rate widths, idle rate and the
// state encoding of the sample-FIFO write-port arbiter.
package sound_pkg;

  localparam int SAMPLE_W = 16;
  localparam int RATE_W   = 16;

  // Rate the sound controller plays at while no producer owns the FIFO.
  localparam logic [RATE_W-1:0] DEFAULT_RATE = 16'd1023;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    GAP
  } arb_state_t;

endpackage

// File: rtl/sound_arb_if.sv
// Producer-side request bundle plus the sample-FIFO write port.
// The slave modport is the arbiter's view.
interface sound_arb_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  import sound_pkg::*;

  logic [NREQ-1:0]          req_valid;
  logic [SAMPLE_W*NREQ-1:0] req_sample;
  logic [RATE_W*NREQ-1:0]   req_rate;
  logic [NREQ-1:0]          req_last;
  logic [NREQ-1:0]          req_ready;
  logic                     grant_valid;
  logic [IDW-1:0]           grant_id;
  logic                     sound_clr_full;
  logic [SAMPLE_W-1:0]      sound_clr_sample;
  logic [RATE_W-1:0]        sound_clr_rate;
  logic                     sound_clr_req;

  modport master (
    output req_valid, req_sample, req_rate, req_last, sound_clr_full,
    input  req_ready, grant_valid, grant_id,
           sound_clr_sample, sound_clr_rate, sound_clr_req
  );

  modport slave (
    input  req_valid, req_sample, req_rate, req_last, sound_clr_full,
    output req_ready, grant_valid, grant_id,
           sound_clr_sample, sound_clr_rate, sound_clr_req
  );

endinterface

// File: rtl/sound_rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, with wrap.
// Purely combinational so it can front any shared audio resource.
module sound_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  pick,
  output logic            any
);

  logic [IDW-1:0] idx;

  // NOTE: every output gets a default first, so no path through the loop can infer a latch.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    // Scan downward so the lowest offset from ptr overwrites last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_arb.sv
// Round-robin owner arbitration of the single sound sample-FIFO write port,
// with grant-time rate latching and a one-cycle gap after every write.
module sound_arb #(
  parameter int                           NREQ         = 2,
  parameter int                           IDW          = 1,
  parameter logic [sound_pkg::RATE_W-1:0] DEFAULT_RATE = sound_pkg::DEFAULT_RATE,
  parameter int                           IDLE_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  sound_arb_if.slave bus
);
  import sound_pkg::*;

  localparam int             CW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'(IDLE_TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic                grant_valid_q, grant_valid_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       idle_cnt_q, idle_cnt_d;
  logic                last_flag_q, last_flag_d;
  logic                clr_req_q, clr_req_d;
  logic [SAMPLE_W-1:0] clr_sample_q, clr_sample_d;
  logic [RATE_W-1:0]   clr_rate_q, clr_rate_d;

  logic [SAMPLE_W-1:0] sample_arr [NREQ];
  logic [RATE_W-1:0]   rate_arr   [NREQ];
  logic [IDW-1:0]      pick_id;
  logic                pick_any;
  logic                own_valid;
  logic                release_own;
  logic [IDW-1:0]      next_ptr;
  logic [NREQ-1:0]     ready;

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign sample_arr[i] = bus.req_sample[SAMPLE_W*i +: SAMPLE_W];
    assign rate_arr[i]   = bus.req_rate[RATE_W*i +: RATE_W];
  end

  sound_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick_id),
    .any  (pick_any)
  );

  assign own_valid = bus.req_valid[grant_id_q];
  assign next_ptr  = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    ready = '0;
    if (state_q == SERVE && !bus.sound_clr_full) ready[grant_id_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    last_flag_d   = last_flag_q;
    clr_req_d     = 1'b0;
    clr_sample_d  = clr_sample_q;
    clr_rate_d    = clr_rate_q;
    release_own   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          clr_rate_d    = rate_arr[pick_id];
          idle_cnt_d    = '0;
          state_d       = SERVE;
        end else begin
          clr_rate_d = DEFAULT_RATE;
        end
      end
      SERVE: begin
        if (own_valid) begin
          // A full FIFO stalls the owner without counting towards the timeout.
          if (!bus.sound_clr_full) begin
            clr_sample_d = sample_arr[grant_id_q];
            clr_req_d    = 1'b1;
            last_flag_d  = bus.req_last[grant_id_q];
            idle_cnt_d   = '0;
            state_d      = GAP;
          end
        end else if (IDLE_TIMEOUT != 0 && idle_cnt_q == TO_LAST) begin
          release_own = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (last_flag_q) release_own = 1'b1;
        else             state_d     = SERVE;
      end
      default: state_d = IDLE;
    endcase

    if (release_own) begin
      grant_valid_d = 1'b0;
      rr_ptr_d      = next_ptr;
      clr_rate_d    = DEFAULT_RATE;
      state_d       = IDLE;
    end
  end

  // NOTE: non-blocking for every registered value so all flops update from the same pre-edge view.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      idle_cnt_q    <= '0;
      last_flag_q   <= 1'b0;
      clr_req_q     <= 1'b0;
      clr_sample_q  <= '0;
      clr_rate_q    <= DEFAULT_RATE;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      last_flag_q   <= last_flag_d;
      clr_req_q     <= clr_req_d;
      clr_sample_q  <= clr_sample_d;
      clr_rate_q    <= clr_rate_d;
    end
  end

  assign bus.req_ready        = ready;
  assign bus.grant_valid      = grant_valid_q;
  assign bus.grant_id         = grant_id_q;
  assign bus.sound_clr_req    = clr_req_q;
  assign bus.sound_clr_sample = clr_sample_q;
  assign bus.sound_clr_rate   = clr_rate_q;

endmodule

// File: tb/tb_sound_arb.sv
// Bench for sound_arb: a cycle table for a single stream, then scoreboarded
// multi-producer sequences covering round-robin, full stalls, timeout and reset.
module tb_sound_arb;
  import sound_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  typedef struct {
    logic [15:0] sample;
    logic        last;
  } item_t;

  typedef struct {
    logic [15:0]    sample;
    logic [15:0]    rate;
    logic [IDW-1:0] id;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] smp;
    logic        last;
    logic [15:0] rate;
    logic [1:0]  e_ready;
    logic        e_gv;
    logic        e_req;
    logic [15:0] e_smp;
    logic [15:0] e_rate;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  sound_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  sound_arb #(
    .NREQ         (NREQ),
    .IDW          (IDW),
    .DEFAULT_RATE (16'd1023),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  item_t       sq [NREQ][$];
  logic [15:0] rate_in [NREQ];
  exp_t        exp_q [$];
  bit          sb_on = 1'b0;
  logic        prev_req = 1'b0;
  logic [NREQ-1:0] xf;

  logic [NREQ-1:0] s_ready;
  logic            s_gv, s_req;
  logic [IDW-1:0]  s_id;
  logic [15:0]     s_rate, s_smp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (sq[i].size() != 0) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_sample[16*i +: 16] = sq[i][0].sample;
        bus.req_last[i]           = sq[i][0].last;
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_sample[16*i +: 16] = 16'h0;
        bus.req_last[i]           = 1'b0;
      end
      bus.req_rate[16*i +: 16] = rate_in[i];
    end
  endtask

  task automatic load(input int id, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) sq[id].push_back('{sample: base + 16'(k), last: (k == n - 1)});
  endtask

  task automatic expect_stream(input int id, input logic [15:0] base, input int n, input logic [15:0] rate);
    for (int k = 0; k < n; k++) exp_q.push_back('{sample: base + 16'(k), rate: rate, id: IDW'(id)});
  endtask

  // One clock: snapshot outputs at the falling edge, then retire accepted samples.
  task automatic step(output logic [NREQ-1:0] xfer);
    @(negedge clk);
    s_ready = bus.req_ready;
    s_gv    = bus.grant_valid;
    s_id    = bus.grant_id;
    s_req   = bus.sound_clr_req;
    s_rate  = bus.sound_clr_rate;
    s_smp   = bus.sound_clr_sample;
    xfer    = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (xfer[i]) void'(sq[i].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input string name);
    int n = 0;
    while ((sq[0].size() != 0 || sq[1].size() != 0 || exp_q.size() != 0) && n < 200) begin
      step(xf);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    repeat (3) step(xf);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) sq[i].delete();
    bus.sound_clr_full = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_strobe", bus.sound_clr_req, 0);
    check("rst_rate", bus.sound_clr_rate, 1023);
    check("rst_ready", bus.req_ready, 0);
    check("rst_sample", bus.sound_clr_sample, 0);
    rst = 1'b1;
  endtask

  // Strobe monitor: spacing rule plus in-order scoreboard comparison.
  always @(negedge clk) begin
    if (bus.sound_clr_req) begin
      check("strobe_spacing", prev_req, 0);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_strobe", exp_q.size(), 1);
        end else begin
          check("sb_sample", bus.sound_clr_sample, exp_q[0].sample);
          check("sb_rate", bus.sound_clr_rate, exp_q[0].rate);
          check("sb_owner", bus.grant_id, exp_q[0].id);
          void'(exp_q.pop_front());
        end
      end
    end
    prev_req <= bus.sound_clr_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    bit   found;
    int   cnt;

    rate_in[0] = 16'd0;
    rate_in[1] = 16'd0;
    bus.sound_clr_full = 1'b0;
    drive();
    do_reset();

    // Idle after reset: nothing moves for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      step(xf);
      check("idle_rate", s_rate, 1023);
      check("idle_strobe", s_req, 0);
      check("idle_grant", s_gv, 0);
      check("idle_ready", s_ready, 0);
    end

    // Single stream on req0, rate 500; mid-stream rate change must be ignored.
    tbl[0]  = '{1'b1, 16'h010, 1'b0, 16'd500, 2'b00, 1'b0, 1'b0, 16'h000, 16'd1023};
    tbl[1]  = '{1'b1, 16'h010, 1'b0, 16'd500, 2'b01, 1'b1, 1'b0, 16'h000, 16'd500};
    tbl[2]  = '{1'b1, 16'h020, 1'b0, 16'd500, 2'b00, 1'b1, 1'b1, 16'h010, 16'd500};
    tbl[3]  = '{1'b1, 16'h020, 1'b0, 16'd500, 2'b01, 1'b1, 1'b0, 16'h010, 16'd500};
    tbl[4]  = '{1'b1, 16'h030, 1'b0, 16'd777, 2'b00, 1'b1, 1'b1, 16'h020, 16'd500};
    tbl[5]  = '{1'b1, 16'h030, 1'b0, 16'd777, 2'b01, 1'b1, 1'b0, 16'h020, 16'd500};
    tbl[6]  = '{1'b1, 16'h040, 1'b1, 16'd500, 2'b00, 1'b1, 1'b1, 16'h030, 16'd500};
    tbl[7]  = '{1'b1, 16'h040, 1'b1, 16'd500, 2'b01, 1'b1, 1'b0, 16'h030, 16'd500};
    tbl[8]  = '{1'b0, 16'h000, 1'b0, 16'd500, 2'b00, 1'b1, 1'b1, 16'h040, 16'd500};
    tbl[9]  = '{1'b0, 16'h000, 1'b0, 16'd500, 2'b00, 1'b0, 1'b0, 16'h040, 16'd1023};
    tbl[10] = '{1'b0, 16'h000, 1'b0, 16'd500, 2'b00, 1'b0, 1'b0, 16'h040, 16'd1023};
    for (int k = 0; k < 11; k++) begin
      bus.req_valid       = {1'b0, tbl[k].v};
      bus.req_sample[15:0] = tbl[k].smp;
      bus.req_last        = {1'b0, tbl[k].last};
      bus.req_rate[15:0]   = tbl[k].rate;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", k), bus.req_ready, tbl[k].e_ready);
      check($sformatf("tbl%0d_grant", k), bus.grant_valid, tbl[k].e_gv);
      check($sformatf("tbl%0d_strobe", k), bus.sound_clr_req, tbl[k].e_req);
      check($sformatf("tbl%0d_sample", k), bus.sound_clr_sample, tbl[k].e_smp);
      check($sformatf("tbl%0d_rate", k), bus.sound_clr_rate, tbl[k].e_rate);
      check($sformatf("tbl%0d_id", k), bus.grant_id, 0);
      @(posedge clk);
      #1;
    end

    // Two producers from reset: req0 first, then req1; a late req0 stream waits.
    do_reset();
    sb_on = 1'b1;
    rate_in[0] = 16'd300;
    rate_in[1] = 16'd600;
    load(0, 16'h0A00, 2);
    load(1, 16'h0B00, 2);
    drive();
    expect_stream(0, 16'h0A00, 2, 16'd300);
    expect_stream(1, 16'h0B00, 2, 16'd600);
    expect_stream(0, 16'h0C00, 1, 16'd350);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step(xf);
      if (s_gv && s_id == 1'b1) found = 1'b1;
    end
    check("rr_req1_granted", found, 1);
    check("rr_req1_rate", s_rate, 600);
    rate_in[1] = 16'd999;
    rate_in[0] = 16'd350;
    load(0, 16'h0C00, 1);
    drive();
    for (int n = 0; n < 3; n++) begin
      step(xf);
      check("rr_req0_held_off", s_ready[0], 0);
    end
    run_until_empty("rr");

    // FIFO full for 10 cycles mid-stream on req1.
    rate_in[1] = 16'h1234;
    load(1, 16'h0D00, 4);
    expect_stream(1, 16'h0D00, 4, 16'h1234);
    drive();
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 2; n++) begin
      step(xf);
      if (xf[1]) cnt++;
    end
    check("full_two_xfers", cnt, 2);
    bus.sound_clr_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(xf);
      check("full_ready", s_ready, 0);
      check("full_owner_kept", s_gv, 1);
      if (k > 0) check("full_no_strobe", s_req, 0);
    end
    bus.sound_clr_full = 1'b0;
    step(xf);
    check("full_resume_xfer", xf, 2'b10);
    step(xf);
    check("full_strobe_next", s_req, 1);
    run_until_empty("full");

    // Owner goes quiet without last: released after 8 idle cycles.
    rate_in[0] = 16'h0100;
    rate_in[1] = 16'h0200;
    load(0, 16'h0E00, 1);
    sq[0][0].last = 1'b0;
    load(1, 16'h0E80, 1);
    expect_stream(0, 16'h0E00, 1, 16'h0100);
    expect_stream(1, 16'h0E80, 1, 16'h0200);
    drive();
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      step(xf);
      if (xf[0]) found = 1'b1;
    end
    check("to_first_xfer", found, 1);
    step(xf);
    check("to_gap_owner", s_gv, 1);
    for (int k = 0; k < 8; k++) begin
      step(xf);
      check("to_idle_ready", s_ready, 2'b01);
      check("to_idle_owner", s_gv, 1);
      check("to_idle_id", s_id, 0);
    end
    step(xf);
    check("to_released", s_gv, 0);
    step(xf);
    check("to_next_grant", s_gv, 1);
    check("to_next_id", s_id, 1);
    check("to_next_rate", s_rate, 16'h0200);
    run_until_empty("to");

    // Reset right after a transfer: strobe dropped, arbitration restarts at req0.
    rate_in[0] = 16'h0300;
    load(0, 16'h0F00, 1);
    expect_stream(0, 16'h0F00, 1, 16'h0300);
    drive();
    run_until_empty("pre_rst");
    rate_in[0] = 16'h0310;
    rate_in[1] = 16'h0320;
    load(1, 16'h0600, 2);
    load(0, 16'h0700, 1);
    drive();
    expect_stream(0, 16'h0700, 1, 16'h0310);
    expect_stream(1, 16'h0600, 2, 16'h0320);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus.req_ready[1] && bus.req_valid[1]) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("mr_req1_xfer_seen", found, 1);
    #2 rst = 1'b0;
    #1;
    check("mr_async_grant", bus.grant_valid, 0);
    check("mr_async_ready", bus.req_ready, 0);
    check("mr_async_rate", bus.sound_clr_rate, 1023);
    check("mr_async_sample", bus.sound_clr_sample, 0);
    @(posedge clk);
    #1;
    check("mr_no_strobe", bus.sound_clr_req, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      step(xf);
      if (s_gv) found = 1'b1;
    end
    check("mr_restart_grant", found, 1);
    check("mr_restart_id", s_id, 0);
    run_until_empty("mr");

    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
